// File: rtl/isp_pkg.sv
// Shared types and constants for the ISP auto-white-balance stage.
package isp_pkg;

    localparam int GAIN_W = 10;

    // Gains are unsigned 2.8 fixed point.
    typedef logic [GAIN_W-1:0] gain_t;

    localparam gain_t GAIN_ONE = 10'h100;
    localparam gain_t GAIN_MAX = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE,
        DIV_R,
        DIV_B,
        DONE
    } awb_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

endpackage

// File: rtl/isp_seq_div.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved on the start cycle,
// so the quotient is ready DVD_W cycles after start, flagged by a one-cycle done pulse.
module isp_seq_div #(
    parameter int DVD_W = 40,
    parameter int DVS_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DVD_W + 1);

    logic [DVS_W-1:0] rem_q, dvs_q, src_rem, src_dvs, rem_n;
    logic [DVD_W-1:0] dvd_q, src_dvd, dvd_n;
    logic [DVS_W:0]   trial;
    logic             fits;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    // Quotient bits shift in at the bottom as dividend bits leave the top.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_dvs = start ? divisor : dvs_q;
        src_dvd = start ? dividend : dvd_q;
        trial   = {src_rem, src_dvd[DVD_W-1]};
        fits    = trial >= {1'b0, src_dvs};
        rem_n   = fits ? DVS_W'(trial - {1'b0, src_dvs}) : trial[DVS_W-1:0];
        dvd_n   = {src_dvd[DVD_W-2:0], fits};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            dvs_q <= '0;
            dvd_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= rem_n;
                dvd_q <= dvd_n;
                dvs_q <= divisor;
                cnt_q <= CNT_W'(DVD_W - 1);
                run_q <= 1'b1;
            end else if (run_q) begin
                rem_q <= rem_n;
                dvd_q <= dvd_n;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign quotient = dvd_q;

endmodule

// File: rtl/isp_awb_gain.sv
// Gray-world auto-white-balance: per-frame channel sums, R/B gain division after frame end,
// and a 2-cycle gain pipeline whose gains switch only at frame start.
module isp_awb_gain
    import isp_pkg::*;
#(
    parameter int               ACC_W    = 32,
    parameter int               GAIN_W   = 10,
    parameter logic [GAIN_W-1:0] GAIN_MAX = 10'h3FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              awb_en,
    input  logic              in_frame,
    input  pix_t              pix_in,
    input  logic              pix_in_vld,
    output pix_t              pix_out,
    output logic              pix_out_vld,
    output logic [GAIN_W-1:0] gain_r,
    output logic [GAIN_W-1:0] gain_b,
    output logic              busy,
    output logic              stats_ovf
);

    localparam int DVD_W  = ACC_W + 8;
    localparam int PROD_W = 8 + GAIN_W;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(GAIN_ONE);

    logic              in_frame_q, frame_rise, frame_fall;
    logic [ACC_W-1:0]  sum_r, sum_g, sum_b, snap_r, snap_g, snap_b;
    logic [ACC_W:0]    add_r, add_g, add_b;
    logic              add_ovf;
    awb_state_t        state, state_n;
    logic              div_start, div_done;
    logic [DVD_W-1:0]  div_dvd, quotient;
    logic [ACC_W-1:0]  div_dvs;
    logic [GAIN_W-1:0] shadow_r, shadow_b, res_r, res_b, quot_sat, gr_eff, gb_eff;
    logic [PROD_W-1:0] s1_prod_r, s1_prod_b;
    logic [7:0]        s1_g;
    logic              s1_vld;

    function automatic logic [7:0] round_sat(input logic [PROD_W-1:0] prod);
        logic [PROD_W:0] s;
        s = {1'b0, prod} + (PROD_W + 1)'(8'h80);
        return (|s[PROD_W:16]) ? 8'hFF : s[15:8];
    endfunction

    assign frame_rise = in_frame & ~in_frame_q;
    assign frame_fall = ~in_frame & in_frame_q;
    assign busy       = (state != IDLE);

    always_comb begin
        add_r   = {1'b0, sum_r} + (ACC_W + 1)'(pix_in.r);
        add_g   = {1'b0, sum_g} + (ACC_W + 1)'(pix_in.g);
        add_b   = {1'b0, sum_b} + (ACC_W + 1)'(pix_in.b);
        add_ovf = add_r[ACC_W] | add_g[ACC_W] | add_b[ACC_W];
    end

    // The R divide is launched straight from the live sums on the frame-end cycle so the
    // busy window is exactly two divides plus DONE.
    // NOTE: every output of this block is given a default first, so no latch can be inferred.
    always_comb begin
        state_n   = state;
        div_start = 1'b0;
        div_dvd   = {snap_g, 8'h00};
        div_dvs   = snap_r;
        unique case (state)
            IDLE: if (frame_fall) begin
                state_n   = DIV_R;
                div_start = (sum_r != '0);
                div_dvd   = {sum_g, 8'h00};
                div_dvs   = sum_r;
            end
            DIV_R: if (snap_r == '0 || div_done) begin
                state_n   = DIV_B;
                div_start = (snap_b != '0);
                div_dvs   = snap_b;
            end
            DIV_B: if (snap_b == '0 || div_done) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign quot_sat = (quotient > DVD_W'(GAIN_MAX)) ? GAIN_MAX : quotient[GAIN_W-1:0];

    isp_seq_div #(
        .DVD_W(DVD_W),
        .DVS_W(ACC_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(div_dvd),
        .divisor (div_dvs),
        .done    (div_done),
        .quotient(quotient)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_frame_q <= 1'b0;
            sum_r      <= '0;
            sum_g      <= '0;
            sum_b      <= '0;
            stats_ovf  <= 1'b0;
        end else begin
            in_frame_q <= in_frame;
            if (frame_rise) begin
                sum_r <= pix_in_vld ? ACC_W'(pix_in.r) : '0;
                sum_g <= pix_in_vld ? ACC_W'(pix_in.g) : '0;
                sum_b <= pix_in_vld ? ACC_W'(pix_in.b) : '0;
            end else if (pix_in_vld) begin
                sum_r <= add_r[ACC_W] ? '1 : add_r[ACC_W-1:0];
                sum_g <= add_g[ACC_W] ? '1 : add_g[ACC_W-1:0];
                sum_b <= add_b[ACC_W] ? '1 : add_b[ACC_W-1:0];
            end
            if ((frame_fall && state != IDLE) || (!frame_rise && pix_in_vld && add_ovf))
                stats_ovf <= 1'b1;
        end
    end

    // res_* start from the current shadow so a skipped divide keeps the previous gain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            snap_r   <= '0;
            snap_g   <= '0;
            snap_b   <= '0;
            res_r    <= UNITY;
            res_b    <= UNITY;
            shadow_r <= UNITY;
            shadow_b <= UNITY;
            gain_r   <= UNITY;
            gain_b   <= UNITY;
        end else begin
            state <= state_n;
            if (state == IDLE && frame_fall) begin
                snap_r <= sum_r;
                snap_g <= sum_g;
                snap_b <= sum_b;
                res_r  <= shadow_r;
                res_b  <= shadow_b;
            end
            if (state == DIV_R && div_done) res_r <= quot_sat;
            if (state == DIV_B && div_done) res_b <= quot_sat;
            if (state == DONE) begin
                shadow_r <= res_r;
                shadow_b <= res_b;
            end
            if (frame_rise) begin
                gain_r <= (state == DONE) ? res_r : shadow_r;
                gain_b <= (state == DONE) ? res_b : shadow_b;
            end
        end
    end

    assign gr_eff = awb_en ? gain_r : UNITY;
    assign gb_eff = awb_en ? gain_b : UNITY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld      <= 1'b0;
            s1_prod_r   <= '0;
            s1_prod_b   <= '0;
            s1_g        <= '0;
            pix_out_vld <= 1'b0;
            pix_out     <= '0;
        end else begin
            s1_vld      <= pix_in_vld;
            pix_out_vld <= s1_vld;
            if (pix_in_vld) begin
                s1_prod_r <= PROD_W'(pix_in.r) * PROD_W'(gr_eff);
                s1_prod_b <= PROD_W'(pix_in.b) * PROD_W'(gb_eff);
                s1_g      <= pix_in.g;
            end
            if (s1_vld) begin
                pix_out.r <= round_sat(s1_prod_r);
                pix_out.g <= s1_g;
                pix_out.b <= round_sat(s1_prod_b);
            end
        end
    end

endmodule

// File: tb/tb_isp_awb_gain.sv
// Bench for isp_awb_gain: table of stats frames with expected gains and test pixels,
// plus hand sequences for bypass, busy collisions, mid-divide reset and start-cycle pixels.
module tb_isp_awb_gain;
    import isp_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        awb_en = 1'b1;
    logic        in_frame = 1'b0;
    logic [23:0] pix_in = '0;
    logic        pix_in_vld = 1'b0;
    pix_t        pix_out;
    logic        pix_out_vld;
    logic [9:0]  gain_r, gain_b;
    logic        busy, stats_ovf;

    isp_awb_gain dut (
        .clk        (clk),
        .reset      (reset),
        .awb_en     (awb_en),
        .in_frame   (in_frame),
        .pix_in     (pix_in),
        .pix_in_vld (pix_in_vld),
        .pix_out    (pix_out),
        .pix_out_vld(pix_out_vld),
        .gain_r     (gain_r),
        .gain_b     (gain_b),
        .busy       (busy),
        .stats_ovf  (stats_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [23:0] exp;
        bit          chk;
    } sb_t;
    sb_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every output pixel pops one entry.
    always @(negedge clk) begin
        if (!reset && pix_out_vld) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pix_unexpected: actual=%0h required=none", pix_out);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                if (e.chk) check("pix_out", pix_out, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [23:0] p, input bit chk, input logic [23:0] exp);
        sb_t e;
        e.exp = exp;
        e.chk = chk;
        sb_q.push_back(e);
        pix_in     = p;
        pix_in_vld = 1'b1;
        tick();
        pix_in_vld = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_frame = 1'b0;
        pix_in_vld = 1'b0;
        idle(2);
        reset = 1'b0;
        sb_q.delete();
        idle(1);
    endtask

    // Counts cycles with busy high until it drops; an expired budget is a failure.
    task automatic wait_idle(input int max_cyc, output int cnt);
        bit ended;
        cnt = 0;
        ended = 1'b0;
        for (int i = 0; i < max_cyc && !ended; i++) begin
            tick();
            if (busy) cnt++;
            else ended = 1'b1;
        end
        if (!ended) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: actual=busy required=idle within %0d", max_cyc);
        end
    endtask

    task automatic stats_frame(input logic [23:0] p, input int n, output int cnt);
        in_frame = 1'b1;
        tick();
        for (int i = 0; i < n; i++) send(p, 1'b0, '0);
        in_frame = 1'b0;
        wait_idle(300, cnt);
    endtask

    typedef struct {
        bit          do_rst;
        logic [23:0] stat;
        int          n;
        int          exp_busy;
        logic [9:0]  gr;
        logic [9:0]  gb;
        logic [23:0] t1, e1, t2, e2;
    } row_t;

    row_t rows[4];

    initial begin
        int cnt;

        rows[0] = '{1'b1, 24'h408080, 4, 81, 10'h200, 10'h100, 24'h408080, 24'h808080, 24'h204040, 24'h404040};
        rows[1] = '{1'b0, 24'h10FFFF, 4, 81, 10'h3FF, 10'h100, 24'h102030, 24'h402030, 24'hC000FF, 24'hFF00FF};
        rows[2] = '{1'b1, 24'h008040, 4, 42, 10'h100, 10'h200, 24'h401140, 24'h401180, 24'h010101, 24'h010102};
        rows[3] = '{1'b0, 24'h204080, 4, 81, 10'h200, 10'h080, 24'h404080, 24'h804040, 24'hFFFFFF, 24'hFFFF80};

        idle(2);
        check("rst_pix_out", pix_out, 24'h0);
        check("rst_pix_out_vld", pix_out_vld, 1'b0);
        check("rst_gain_r", gain_r, 10'h100);
        check("rst_gain_b", gain_b, 10'h100);
        check("rst_busy", busy, 1'b0);
        check("rst_stats_ovf", stats_ovf, 1'b0);
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 4; i++) begin
            if (rows[i].do_rst) do_reset();
            stats_frame(rows[i].stat, rows[i].n, cnt);
            check($sformatf("row%0d_busy_cycles", i), cnt, rows[i].exp_busy);
            in_frame = 1'b1;
            tick();
            check($sformatf("row%0d_gain_r", i), gain_r, rows[i].gr);
            check($sformatf("row%0d_gain_b", i), gain_b, rows[i].gb);
            send(rows[i].t1, 1'b1, rows[i].e1);
            send(rows[i].t2, 1'b1, rows[i].e2);
            idle(3);
            in_frame = 1'b0;
            wait_idle(300, cnt);
        end

        // Bypass with 0x200/0x080 still active.
        awb_en = 1'b0;
        check("bypass_gain_r", gain_r, 10'h200);
        check("bypass_gain_b", gain_b, 10'h080);
        begin
            sb_t e;
            e.exp = 24'hA5C33C;
            e.chk = 1'b1;
            sb_q.push_back(e);
            pix_in = 24'hA5C33C;
            pix_in_vld = 1'b1;
            tick();
            pix_in_vld = 1'b0;
            check("latency_stage1_vld", pix_out_vld, 1'b0);
            tick();
            check("latency_stage2_vld", pix_out_vld, 1'b1);
            tick();
            check("latency_vld_drop", pix_out_vld, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            logic [23:0] p;
            p = 24'($urandom);
            send(p, 1'b1, p);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(3);
        awb_en = 1'b1;

        // Frame end 10 cycles into a divide is dropped; the first frame's gains commit.
        do_reset();
        in_frame = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(24'h408080, 1'b0, '0);
        in_frame = 1'b0;
        tick();
        check("collide_busy_start", busy, 1'b1);
        idle(2);
        in_frame = 1'b1;
        tick();
        send(24'h102030, 1'b0, '0);
        send(24'h102030, 1'b0, '0);
        idle(4);
        in_frame = 1'b0;
        tick();
        check("collide_stats_ovf", stats_ovf, 1'b1);
        wait_idle(300, cnt);
        check("collide_busy_remaining", cnt, 70);
        in_frame = 1'b1;
        tick();
        check("collide_gain_r", gain_r, 10'h200);
        check("collide_gain_b", gain_b, 10'h100);
        check("collide_ovf_sticky", stats_ovf, 1'b1);

        // Reset 20 cycles into a divide aborts it with nothing committed.
        for (int i = 0; i < 4; i++) send(24'h10FFFF, 1'b0, '0);
        in_frame = 1'b0;
        tick();
        idle(19);
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_gain_r", gain_r, 10'h100);
        check("abort_gain_b", gain_b, 10'h100);
        check("abort_stats_ovf", stats_ovf, 1'b0);
        tick();
        reset = 1'b0;
        sb_q.delete();
        idle(1);
        in_frame = 1'b1;
        tick();
        check("abort_no_commit_r", gain_r, 10'h100);
        check("abort_no_commit_b", gain_b, 10'h100);
        in_frame = 1'b0;
        wait_idle(300, cnt);
        check("empty_frame_busy", cnt, 3);

        // Pixel on the frame-start cycle is the whole frame's statistics.
        do_reset();
        in_frame = 1'b1;
        send(24'h010203, 1'b0, '0);
        in_frame = 1'b0;
        wait_idle(300, cnt);
        check("start_pix_busy", cnt, 81);
        in_frame = 1'b1;
        tick();
        check("start_pix_gain_r", gain_r, 10'h200);
        check("start_pix_gain_b", gain_b, 10'h0AA);
        in_frame = 1'b0;
        wait_idle(300, cnt);
        idle(3);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
